// File: rtl/a5_keystream_gen.sv
// a5_keystream_gen
//   A5/1 keystream generator. Three majority-clocked LFSRs are loaded with a
//   64-bit key and a 22-bit frame number. After MIX_CYCLES warm-up steps the
//   core produces NUM_BITS keystream bits, one per clock. The bits are packed
//   MSB-first into 32-bit words and handed off over a valid/ready interface.
//   Generation stalls whenever a finished word cannot be handed off.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   load              start pulse; key/frame sampled on this edge (restarts if busy)
//   key[63:0]         session key, bit i injected at key step i
//   frame[21:0]       frame number, bit i injected at frame step i
//   out_data[31:0]    packed keystream word (final word zero-padded low)
//   out_valid         out_data holds a word not yet accepted
//   out_ready         consumer accepts the word when out_valid && out_ready
//   busy              high from load until the last word is accepted
//   done              one-cycle pulse after the final word is accepted
//   out_last          (A5_WORD_LAST_EN only) marks the final word
//
// Build option
//   A5_WORD_LAST_EN   adds the out_last output port.
module a5_keystream_gen #(
  parameter int NUM_BITS   = 228,
  parameter int MIX_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef A5_WORD_LAST_EN
  ,
  output logic        out_last
`endif
);

  // one counter serves key steps, frame steps, warm-up steps and bit index
  localparam int CNT_MAX = (NUM_BITS > MIX_CYCLES)
                         ? ((NUM_BITS   > 64) ? NUM_BITS   : 64)
                         : ((MIX_CYCLES > 64) ? MIX_CYCLES : 64);
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, KEY, FRAME, MIX, GEN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [18:0]       r1, r1_nx;
  logic [21:0]       r2, r2_nx;
  logic [22:0]       r3, r3_nx;
  logic [63:0]       key_q;
  logic [21:0]       frame_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       acc;
  logic [4:0]        acc_cnt;   // bits currently held in acc

  logic        maj, inj, step_all, step_maj, gen_step, advance;
  logic        last_bit, word_done, can_xfer, ks_bit;
  logic [31:0] word;

  assign maj       = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
  assign last_bit  = (cnt == CNT_W'(NUM_BITS - 1));
  assign word_done = (acc_cnt == 5'd31) || last_bit;
  // zero-bubble: a new word may replace one being accepted this cycle
  assign can_xfer  = !out_valid || out_ready;

  // next-state / step control
  always_comb begin
    state_d  = state_q;
    step_all = 1'b0;
    step_maj = 1'b0;
    inj      = 1'b0;
    gen_step = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      KEY: begin
        step_all = 1'b1;
        inj      = key_q[0];
        advance  = 1'b1;
        if (cnt == CNT_W'(63)) state_d = FRAME;
      end
      FRAME: begin
        step_all = 1'b1;
        inj      = frame_q[0];
        advance  = 1'b1;
        if (cnt == CNT_W'(21)) state_d = MIX;
      end
      MIX: begin
        step_maj = 1'b1;
        advance  = 1'b1;
        if (cnt == CNT_W'(MIX_CYCLES - 1)) state_d = GEN;
      end
      GEN: begin
        // hold everything if this step would finish a word with nowhere to go
        if (!word_done || can_xfer) begin
          step_maj = 1'b1;
          gen_step = 1'b1;
          advance  = 1'b1;
          if (last_bit) state_d = DRAIN;
        end
      end
      DRAIN: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) state_d = KEY;
  end

  // LFSR step; the injected bit is folded into the feedback at bit 0
  always_comb begin
    r1_nx = r1;
    r2_nx = r2;
    r3_nx = r3;
    if (step_all || (step_maj && (r1[8] == maj)))
      r1_nx = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ inj};
    if (step_all || (step_maj && (r2[10] == maj)))
      r2_nx = {r2[20:0], r2[20] ^ r2[21] ^ inj};
    if (step_all || (step_maj && (r3[10] == maj)))
      r3_nx = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ inj};
  end

  // keystream bit comes from the post-step state
  assign ks_bit = r1_nx[18] ^ r2_nx[21] ^ r3_nx[22];
  // left-justify: a full word needs no shift, a short final word is padded low
  assign word   = {acc[30:0], ks_bit} << (5'd31 - acc_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      key_q     <= '0;
      frame_q   <= '0;
      cnt       <= '0;
      acc       <= '0;
      acc_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef A5_WORD_LAST_EN
      out_last  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        // fresh start or abort: drop any pending/partial output, no done
        key_q     <= key;
        frame_q   <= frame;
        r1        <= '0;
        r2        <= '0;
        r3        <= '0;
        cnt       <= '0;
        acc       <= '0;
        acc_cnt   <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b1;
`ifdef A5_WORD_LAST_EN
        out_last  <= 1'b0;
`endif
      end else begin
        r1 <= r1_nx;
        r2 <= r2_nx;
        r3 <= r3_nx;
        if (state_q == KEY)   key_q   <= key_q >> 1;
        if (state_q == FRAME) frame_q <= frame_q >> 1;

        if (state_d != state_q) cnt <= '0;
        else if (advance)       cnt <= cnt + 1'b1;

        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
`ifdef A5_WORD_LAST_EN
          out_last  <= 1'b0;
`endif
        end

        if (gen_step) begin
          if (word_done) begin
            out_data  <= word;
            out_valid <= 1'b1;
`ifdef A5_WORD_LAST_EN
            out_last  <= last_bit;
`endif
            acc       <= '0;
            acc_cnt   <= '0;
          end else begin
            acc     <= {acc[30:0], ks_bit};
            acc_cnt <= acc_cnt + 1'b1;
          end
        end

        if (state_q == DRAIN && out_valid && out_ready) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
